// File: rtl/qcmd_dispatch.sv
// qcmd_dispatch: routes strobed sequencer commands into per-element FWFT FIFOs (optional head timestamps: QCMD_DISPATCH_TSTAMP_EN)
module qcmd_dispatch #(
    parameter int nell    = 3,
    parameter int fifo_aw = 4,
    parameter int cw      = 64,
    parameter int ew      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [cw-1:0]                 command,
    input  logic [7:0]                    cmda,
    input  logic [ew-1:0]                 extra,
    input  logic                          cstrobe,
    input  logic                          flush,
    output logic [nell*cw-1:0]            ch_cmd,
    output logic [nell*ew-1:0]            ch_extra,
    output logic [nell-1:0]               ch_valid,
    input  logic [nell-1:0]               ch_ready,
    output logic [nell*(fifo_aw+1)-1:0]   ch_level,
    output logic [nell-1:0]               ovf_flag,
    output logic [15:0]                   bad_addr_cnt,
`ifdef QCMD_DISPATCH_TSTAMP_EN
    output logic [nell*24-1:0]            ch_tstamp,
`endif
    output logic [15:0]                   drop_cnt
);
    localparam int dep = 1 << fifo_aw;
    localparam int lw  = fifo_aw + 1;
`ifdef QCMD_DISPATCH_TSTAMP_EN
    localparam int dw  = cw + ew + 24;
    logic [23:0] ts;
`else
    localparam int dw  = cw + ew;
`endif

    logic [dw-1:0]      mem    [nell][dep];
    logic [lw-1:0]      rp     [nell];
    logic [lw-1:0]      wp     [nell];
    logic [dw-1:0]      head   [nell];
    logic [lw-1:0]      lvl    [nell];
    logic [lw-1:0]      lvl_n  [nell];
    logic [lw-1:0]      rp_n   [nell];
    logic [lw-1:0]      wp_n   [nell];
    logic [dw-1:0]      head_n [nell];
    logic [fifo_aw-1:0] waddr  [nell];
    logic [nell-1:0]    push, pop, acc, drop;
    logic [dw-1:0]      wdata;
    logic               bad;

`ifdef QCMD_DISPATCH_TSTAMP_EN
    assign wdata = {command, extra, ts};
`else
    assign wdata = {command, extra};
`endif
    assign bad = cstrobe && (cmda >= 8'(nell));

    // per-channel accept/drop decision, next pointers and next registered head
    always_comb begin
        for (int k = 0; k < nell; k++) begin
            lvl[k]    = wp[k] - rp[k];
            push[k]   = cstrobe && (cmda == 8'(k));
            pop[k]    = (lvl[k] != '0) && ch_ready[k] && !flush;
            acc[k]    = push[k] && (flush || !lvl[k][fifo_aw] || pop[k]);
            drop[k]   = push[k] && !acc[k];
            rp_n[k]   = flush ? '0 : rp[k] + lw'(pop[k]);
            wp_n[k]   = (flush ? '0 : wp[k]) + lw'(acc[k]);
            waddr[k]  = flush ? '0 : wp[k][fifo_aw-1:0];
            lvl_n[k]  = wp_n[k] - rp_n[k];
            head_n[k] = (lvl_n[k] == '0) ? '0 :
                        (acc[k] && (waddr[k] == rp_n[k][fifo_aw-1:0])) ? wdata :
                        mem[k][rp_n[k][fifo_aw-1:0]];
        end
    end

    // pointers, head registers and sticky/saturating diagnostics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < nell; k++) begin
                rp[k]   <= '0;
                wp[k]   <= '0;
                head[k] <= '0;
            end
            ovf_flag     <= '0;
            bad_addr_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            for (int k = 0; k < nell; k++) begin
                rp[k]   <= rp_n[k];
                wp[k]   <= wp_n[k];
                head[k] <= head_n[k];
            end
            ovf_flag <= ovf_flag | drop;
            if (bad && (bad_addr_cnt != 16'hFFFF))
                bad_addr_cnt <= bad_addr_cnt + 16'd1;
            if ((|drop) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // entry storage; occupancy lives in the pointers, so contents need no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < nell; k++)
            if (acc[k])
                mem[k][waddr[k]] <= wdata;
    end

`ifdef QCMD_DISPATCH_TSTAMP_EN
    // free-running push timestamp, restarted by reset and by trig flush
    always_ff @(posedge clk) begin
        ts <= (!rst_n || flush) ? '0 : ts + 24'd1;
    end
`endif

    // unpack registered heads and levels onto the flat channel buses
    always_comb begin
        for (int k = 0; k < nell; k++) begin
            ch_cmd[k*cw +: cw]     = head[k][dw-1 -: cw];
            ch_extra[k*ew +: ew]   = head[k][dw-cw-1 -: ew];
            ch_valid[k]            = lvl[k] != '0;
            ch_level[k*lw +: lw]   = lvl[k];
`ifdef QCMD_DISPATCH_TSTAMP_EN
            ch_tstamp[k*24 +: 24]  = head[k][23:0];
`endif
        end
    end
endmodule

// File: tb/tb_qcmd_dispatch.sv
// tb_qcmd_dispatch: vector table, directed corner sequences and random traffic against a queue model
module tb_qcmd_dispatch;
    localparam int NELL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, cstrobe, flush;
    logic [63:0]          command;
    logic [7:0]           cmda;
    logic [31:0]          extra;
    logic [NELL-1:0]      ch_ready, ch_valid, ovf_flag;
    logic [NELL*64-1:0]   ch_cmd;
    logic [NELL*32-1:0]   ch_extra;
    logic [NELL*5-1:0]    ch_level;
    logic [15:0]          bad_addr_cnt, drop_cnt;
`ifdef QCMD_DISPATCH_TSTAMP_EN
    logic [NELL*24-1:0]   ch_tstamp;
`endif

    qcmd_dispatch #(.nell(NELL), .fifo_aw(4), .cw(64), .ew(32)) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .cmda(cmda), .extra(extra),
        .cstrobe(cstrobe), .flush(flush), .ch_cmd(ch_cmd), .ch_extra(ch_extra),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_level(ch_level),
        .ovf_flag(ovf_flag), .bad_addr_cnt(bad_addr_cnt),
`ifdef QCMD_DISPATCH_TSTAMP_EN
        .ch_tstamp(ch_tstamp),
`endif
        .drop_cnt(drop_cnt)
    );

    typedef struct packed { logic [63:0] c; logic [31:0] e; } ent_t;
    ent_t            q [NELL][$];
    logic [NELL-1:0] ovf_m;
    int              bad_m, drop_m;
    int              n_chk = 0, n_fail = 0;

    typedef struct {
        logic r, cs; logic [7:0] a; logic [63:0] c; logic [31:0] e; logic f; logic [2:0] rdy;
        logic [2:0] ev; logic [14:0] el; logic [15:0] eb, ed; logic [63:0] ec1;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // spec-level model: one queue per element, capacity 16
    task automatic model_update();
        if (!rst_n) begin
            for (int k = 0; k < NELL; k++) q[k].delete();
            ovf_m = '0; bad_m = 0; drop_m = 0;
            return;
        end
        if (cstrobe && cmda >= NELL && bad_m < 65535) bad_m++;
        for (int k = 0; k < NELL; k++) begin
            if (flush) q[k].delete();
            else if (ch_ready[k] && q[k].size() > 0) void'(q[k].pop_front());
            if (cstrobe && cmda == k) begin
                if (q[k].size() < 16) q[k].push_back(ent_t'{c: command, e: extra});
                else begin
                    ovf_m[k] = 1'b1;
                    if (drop_m < 65535) drop_m++;
                end
            end
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < NELL; k++) begin
            chk($sformatf("model valid[%0d]", k), ch_valid[k], q[k].size() > 0);
            chk($sformatf("model level[%0d]", k), ch_level[k*5 +: 5], q[k].size());
            if (q[k].size() > 0) begin
                chk($sformatf("model cmd[%0d]", k), ch_cmd[k*64 +: 64], q[k][0].c);
                chk($sformatf("model extra[%0d]", k), ch_extra[k*32 +: 32], q[k][0].e);
            end
        end
        chk("model ovf", ovf_flag, ovf_m);
        chk("model bad_cnt", bad_addr_cnt, bad_m);
        chk("model drop_cnt", drop_cnt, drop_m);
    endtask

    task automatic step(input logic r, input logic cs, input logic [7:0] a, input logic [63:0] c,
                        input logic [31:0] e, input logic f, input logic [2:0] rdy);
        rst_n = r; cstrobe = cs; cmda = a; command = c; extra = e; flush = f; ch_ready = rdy;
        @(posedge clk);
        model_update();
        #1;
        cmp_model();
    endtask

    initial begin
        rst_n = 1'b0; cstrobe = 1'b0; cmda = '0; command = '0; extra = '0; flush = 1'b0; ch_ready = '0;
        ovf_m = '0; bad_m = 0; drop_m = 0;
        tbl[0] = '{1'b0, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b000, 3'b000, 15'h0000, 16'd0, 16'd0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 8'd1, 64'h0123456789ABCDEF, 32'h55, 1'b0, 3'b000, 3'b010, 15'h0020, 16'd0, 16'd0, 64'h0123456789ABCDEF};
        tbl[2] = '{1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b101, 3'b010, 15'h0020, 16'd0, 16'd0, 64'h0123456789ABCDEF};
        tbl[3] = '{1'b1, 1'b1, 8'd5, 64'hDEAD, 32'h1, 1'b0, 3'b000, 3'b010, 15'h0020, 16'd1, 16'd0, 64'h0123456789ABCDEF};
        tbl[4] = '{1'b1, 1'b1, 8'd3, 64'hBEEF, 32'h2, 1'b0, 3'b000, 3'b010, 15'h0020, 16'd2, 16'd0, 64'h0123456789ABCDEF};
        tbl[5] = '{1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b010, 3'b000, 15'h0000, 16'd2, 16'd0, 64'h0};
        tbl[6] = '{1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b111, 3'b000, 15'h0000, 16'd2, 16'd0, 64'h0};
        tbl[7] = '{1'b1, 1'b1, 8'd2, 64'h7, 32'h0, 1'b0, 3'b000, 3'b100, 15'h0400, 16'd2, 16'd0, 64'h0};
        tbl[8] = '{1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b1, 3'b000, 3'b000, 15'h0000, 16'd2, 16'd0, 64'h0};

        step(1'b0, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b000);
        chk("reset ch_cmd", ch_cmd[127:0], 128'h0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].cs, tbl[i].a, tbl[i].c, tbl[i].e, tbl[i].f, tbl[i].rdy);
            chk($sformatf("vec%0d valid", i), ch_valid, tbl[i].ev);
            chk($sformatf("vec%0d level", i), ch_level, tbl[i].el);
            chk($sformatf("vec%0d bad_cnt", i), bad_addr_cnt, tbl[i].eb);
            chk($sformatf("vec%0d drop_cnt", i), drop_cnt, tbl[i].ed);
            if (tbl[i].ev[1]) chk($sformatf("vec%0d ch1 cmd", i), ch_cmd[127:64], tbl[i].ec1);
        end

        // overflow: 17 strobes to a stalled channel
        for (int i = 0; i <= 16; i++) step(1'b1, 1'b1, 8'd0, 64'(i), 32'(i), 1'b0, 3'b000);
        chk("full level0", ch_level[4:0], 5'd16);
        chk("full ovf", ovf_flag, 3'b001);
        chk("full drop_cnt", drop_cnt, 16'd1);
        chk("full head", ch_cmd[63:0], 64'd0);
        // push and pop together at full
        step(1'b1, 1'b1, 8'd0, 64'd100, 32'd100, 1'b0, 3'b001);
        chk("fullpp level0", ch_level[4:0], 5'd16);
        chk("fullpp drop_cnt", drop_cnt, 16'd1);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain head%0d", j), ch_cmd[63:0], (j < 15) ? 64'(j + 1) : 64'd100);
            step(1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b001);
        end
        chk("drained valid0", ch_valid[0], 1'b0);

        // flush coinciding with a strobe keeps the new command
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd2, 64'h10 + 64'(i), 32'h0, 1'b0, 3'b000);
        chk("pre-flush level2", ch_level[14:10], 5'd4);
        step(1'b1, 1'b1, 8'd2, 64'hAA, 32'hBB, 1'b1, 3'b000);
        chk("flush level2", ch_level[14:10], 5'd1);
        chk("flush head2", ch_cmd[191:128], 64'hAA);
        chk("flush extra2", ch_extra[95:64], 32'hBB);
        chk("flush ovf", ovf_flag, 3'b001);
        chk("flush drop_cnt", drop_cnt, 16'd1);
        chk("flush bad_cnt", bad_addr_cnt, 16'd2);

        // reset mid-operation with strobe and ready active
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd0, 64'h30 + 64'(i), 32'h0, 1'b0, 3'(i & 2));
        chk("pre-rst level0", ch_level[4:0], 5'd3);
        step(1'b0, 1'b1, 8'd0, 64'h99, 32'h99, 1'b1, 3'b111);
        chk("rst valid", ch_valid, 3'b000);
        chk("rst level", ch_level, 15'h0);
        chk("rst cmd", ch_cmd, 192'h0);
        chk("rst extra", ch_extra, 96'h0);
        chk("rst ovf", ovf_flag, 3'b000);
        chk("rst bad_cnt", bad_addr_cnt, 16'd0);
        chk("rst drop_cnt", drop_cnt, 16'd0);
        step(1'b1, 1'b0, 8'd0, 64'h0, 32'h0, 1'b0, 3'b111);
        step(1'b1, 1'b1, 8'd0, 64'h77, 32'h78, 1'b0, 3'b000);
        chk("post-rst valid", ch_valid, 3'b001);
        chk("post-rst head", ch_cmd[63:0], 64'h77);
        chk("post-rst level", ch_level, 15'h0001);

        // random traffic with alternating stall and drain phases
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] rdy;
            for (int k = 0; k < NELL; k++) rdy[k] = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 4)),
                 {$urandom, $urandom}, $urandom, ($urandom_range(0, 149) == 0), rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
